rv_plic_claimer: RTL
====================

RV_PLIC_CLAIMER -- requirements
Module: rv_plic_claimer

Interface
REQ-001 Parameter NumSrc, default 64, number of interrupt sources; SRCW = $clog2(NumSrc), derived.
REQ-002 Parameter CcAddr, default 32'h0000_0200, TL-UL byte address of the target's CC (claim/complete) register.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 irq_i  input  1  interrupt request from the PLIC target.
REQ-006 irq_id_i  input  SRCW  PLIC's current highest-priority ID; informational only, never used as the claimed ID.
REQ-007 tl_o  output  tlul_pkg::tl_h2d_t  TL-UL host request channel to the PLIC register port.
REQ-008 tl_i  input  tlul_pkg::tl_d2h_t  TL-UL device response channel.
REQ-009 id_valid_o / id_o / id_ready_i  out/out/in  1/SRCW/1  claimed-ID handoff to the handler, valid/ready.
REQ-010 cmpl_valid_i / cmpl_id_i / cmpl_ready_o  in/in/out  1/SRCW/1  handler completion request, valid/ready.
REQ-011 err_o  output  1  one-cycle pulse on any TL-UL d_error.

Function
REQ-012 FSM states: IDLE, CLM_REQ, CLM_RSP, PRESENT, WAIT_CMPL, CMP_REQ, CMP_RSP.
REQ-013 IDLE -> CLM_REQ when irq_i=1; irq_i is sampled only in IDLE.
REQ-014 CLM_REQ: a_valid=1, a_opcode=Get, a_address=CcAddr, a_size=2, a_mask=4'hF, a_source=0; -> CLM_RSP on the cycle a_valid&&a_ready.
REQ-015 CLM_RSP: capture d_data[SRCW-1:0] into the ID register on d_valid; ID==0 (spurious) -> IDLE; d_error -> err_o pulse, -> IDLE; otherwise -> PRESENT.
REQ-016 PRESENT: id_valid_o=1, id_o=captured ID, held stable until id_valid_o&&id_ready_i; then -> WAIT_CMPL.
REQ-017 WAIT_CMPL: cmpl_ready_o=1; on cmpl_valid_i latch cmpl_id_i (zero-extended to 32 bits) and -> CMP_REQ; cmpl_ready_o=0 in every other state.
REQ-018 CMP_REQ: a_valid=1, a_opcode=PutFullData, a_address=CcAddr, a_data=latched ID, a_size=2, a_mask=4'hF, a_source=0; -> CMP_RSP on handshake.
REQ-019 CMP_RSP: on d_valid -> IDLE; d_error additionally pulses err_o.
REQ-020 d_ready=1 in all states; exactly one TL-UL transaction outstanding at any time.
REQ-021 A request's a_* fields are held stable from a_valid assertion until a_ready, and a_valid never deasserts before the handshake.
REQ-022 cmpl_id_i differing from the claimed ID is written as given (PLIC ignores mismatches); no local check.
REQ-023 Minimum turnaround: irq_i high in IDLE with a_ready=1 and d_valid on the next cycle -> id_valid_o asserts 3 cycles after irq_i is sampled.
REQ-024 Unused tl_o fields (a_param, a_user) are driven to 0.
REQ-025 d_valid in a state other than CLM_RSP or CMP_RSP is ignored.

Reset
REQ-026 rst_ni=0 at a clock edge -> state IDLE, ID register 0, tl_o.a_valid=0, id_valid_o=0, cmpl_ready_o=0, err_o=0, from the following cycle.
REQ-027 Reset asserted mid-transaction abandons the transaction; no retry occurs after reset.

Structure
REQ-028 The FSM state enum is a typedef in a package rv_plic_claimer_pkg; TL opcodes come from tlul_pkg; CcAddr stays a module parameter.
REQ-029 Single flat module, no sub-modules; registered TL request outputs.

Verification
REQ-030 irq_i=1, device returns d_data=5 -> id_o=5 presented; cmpl_id_i=5 -> PutFullData to CcAddr with a_data=32'h5; FSM back in IDLE.
REQ-031 Claim returns 0 -> id_valid_o stays 0 and no PutFullData is issued; FSM returns to IDLE.
REQ-032 a_ready held 0 for 4 cycles -> a_valid and a_address remain stable for all 4 cycles; handshake on cycle 5.
REQ-033 Claim response with d_error=1 -> err_o is high for exactly 1 cycle, no ID is presented, FSM returns to IDLE.
REQ-034 id_ready_i=0 for 10 cycles, with irq_i toggling -> id_o is unchanged and no new Get is issued.
REQ-035 rst_ni=0 asserted in CMP_REQ -> a_valid=0 the next cycle; after release, irq_i=1 starts a fresh Get.

Source files
------------

// File: rtl/rv_plic_claimer_pkg.sv
// rtl/rv_plic_claimer_pkg.sv - claimer FSM states and fixed request attributes
package rv_plic_claimer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLM_REQ   = 3'd1,
    CLM_RSP   = 3'd2,
    PRESENT   = 3'd3,
    WAIT_CMPL = 3'd4,
    CMP_REQ   = 3'd5,
    CMP_RSP   = 3'd6
  } claim_state_e;

  // CC register is always accessed as a full 32-bit word
  localparam logic [1:0] TL_SIZE_WORD = 2'd2;
  localparam logic [3:0] TL_MASK_FULL = 4'hF;

endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel types and opcodes
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [7:0]  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [7:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/rv_plic_claimer.sv
// rtl/rv_plic_claimer.sv - PLIC claim/complete sequencer over TL-UL
module rv_plic_claimer
  import rv_plic_claimer_pkg::*;
#(
  parameter int          NumSrc = 64,
  parameter logic [31:0] CcAddr = 32'h0000_0200,
  localparam int         SRCW   = $clog2(NumSrc)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                irq_i,
  input  logic [SRCW-1:0]     irq_id_i,
  output tlul_pkg::tl_h2d_t   tl_o,
  input  tlul_pkg::tl_d2h_t   tl_i,
  output logic                id_valid_o,
  output logic [SRCW-1:0]     id_o,
  input  logic                id_ready_i,
  input  logic                cmpl_valid_i,
  input  logic [SRCW-1:0]     cmpl_id_i,
  output logic                cmpl_ready_o,
  output logic                err_o
);

  claim_state_e       state;
  logic [SRCW-1:0]    id_q;
  logic               a_valid_q;
  tlul_pkg::tl_a_op_e a_opcode_q;
  logic [31:0]        a_data_q;

  // The ID is always taken from the claim read; irq_id_i is only a hint, and
  // most response fields carry nothing this block needs.
  logic unused_inputs;
  assign unused_inputs = ^{irq_id_i, tl_i};

  assign id_o = id_q;

  // Request fields are only loaded on entry to a *_REQ state, so they stay
  // stable for as long as the device withholds a_ready.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      id_q         <= '0;
      a_valid_q    <= 1'b0;
      a_opcode_q   <= tlul_pkg::Get;
      a_data_q     <= '0;
      id_valid_o   <= 1'b0;
      cmpl_ready_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (irq_i) begin
            a_valid_q  <= 1'b1;
            a_opcode_q <= tlul_pkg::Get;
            a_data_q   <= '0;
            state      <= CLM_REQ;
          end
        end
        CLM_REQ: begin
          if (a_valid_q && tl_i.a_ready) begin
            a_valid_q <= 1'b0;
            state     <= CLM_RSP;
          end
        end
        CLM_RSP: begin
          if (tl_i.d_valid) begin
            id_q <= tl_i.d_data[SRCW-1:0];
            if (tl_i.d_error) begin
              err_o <= 1'b1;
              state <= IDLE;
            end else if (tl_i.d_data[SRCW-1:0] == '0) begin
              // ID 0 means nothing pending any more: spurious, nothing to complete
              state <= IDLE;
            end else begin
              id_valid_o <= 1'b1;
              state      <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (id_ready_i) begin
            id_valid_o   <= 1'b0;
            cmpl_ready_o <= 1'b1;
            state        <= WAIT_CMPL;
          end
        end
        WAIT_CMPL: begin
          if (cmpl_valid_i) begin
            cmpl_ready_o <= 1'b0;
            a_valid_q    <= 1'b1;
            a_opcode_q   <= tlul_pkg::PutFullData;
            a_data_q     <= {{(32-SRCW){1'b0}}, cmpl_id_i};
            state        <= CMP_REQ;
          end
        end
        CMP_REQ: begin
          if (a_valid_q && tl_i.a_ready) begin
            a_valid_q <= 1'b0;
            state     <= CMP_RSP;
          end
        end
        CMP_RSP: begin
          if (tl_i.d_valid) begin
            err_o <= tl_i.d_error;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Assemble the host channel from registered fields; unused fields stay zero
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid_q;
    tl_o.a_opcode  = a_opcode_q;
    tl_o.a_size    = TL_SIZE_WORD;
    tl_o.a_source  = '0;
    tl_o.a_address = CcAddr;
    tl_o.a_mask    = TL_MASK_FULL;
    tl_o.a_data    = a_data_q;
    tl_o.d_ready   = 1'b1;
  end

endmodule
